sr_driver: RTL
==============

# sr_driver

Synchronous command-driven front end for the cross-coupled SR latch. Accepts set/reset requests over a valid/ready handshake and drives the latch's `set`/`rst` inputs with glitch-free, mutually exclusive pulses of fixed width. Reads back `q`/`q_` to confirm the latch reached the requested state, and reports completion or timeout. Sits between clocked control logic and the asynchronous latch, so no clocked block ever drives the latch pins directly.

## Interface
- `PULSE_W`, default 4: cycles `set` or `rst` stays high per command; legal range 1–255.
- `TIMEOUT`, default 16: cycles allowed in WAIT for readback to match before `err`; legal range 1–255.
- `clk  in  1`: single clock; every register updates on the rising edge.
- `rst_n  in  1`: reset, **synchronous and active-low**.
- `cmd_valid  in  1`: command request.
- `cmd_val  in  1`: requested latch state; 1 means set (q=1), 0 means reset (q=0).
- `cmd_ready  out  1`: block is idle and accepts a command (registered).
- `set  out  1`: latch set drive (registered).
- `rst  out  1`: latch reset drive (registered).
- `q  in  1`: latch true output; asynchronous.
- `q_  in  1`: latch complementary output; asynchronous.
- `done  out  1`: one-cycle pulse; readback matched `cmd_val`.
- `err  out  1`: one-cycle pulse; readback did not match within TIMEOUT.
- `busy  out  1`: high in PULSE and WAIT.

## Operation
- FSM states: IDLE, PULSE, WAIT.
- **IDLE:** `cmd_ready`=1.
  - A handshake (`cmd_valid & cmd_ready` at an edge) captures `cmd_val` and moves to PULSE.
  - Once the handshake is sampled, `cmd_ready` is 0 in the following cycle.
- **PULSE:** drives `set`=`cmd_val` and `rst`=~`cmd_val` for exactly PULSE_W cycles. A counter then clears both and moves to WAIT.
- **WAIT:** both drives are 0. At each edge, the block compares readback `q`==`cmd_val` and `q_`==~`cmd_val`.
  - On a match: go to IDLE, with `done`=1 and `cmd_ready`=1 in the next cycle.
  - After TIMEOUT edges without a match: go to IDLE, with `err`=1 and `cmd_ready`=1 in the next cycle.
  - `done` and `err` are never high in the same cycle.
- **Invariants:**
  - `set` and `rst` are never both 1 in any cycle, including across reset.
  - A command is always pulsed, even if the latch already holds the requested value.
- `cmd_valid` outside IDLE is ignored. It does not queue.
- Counter width is $clog2(max(PULSE_W, TIMEOUT)+1). Counters saturate and never wrap.

## Timing
- **Reset values:** `cmd_ready`=0, `set`=0, `rst`=0, `done`=0, `err`=0, `busy`=0, FSM=IDLE, counters=0.
- `cmd_ready` rises in the first cycle after the first edge that samples `rst_n`=1.
- **Handshake and pulse:**
  - The handshake is sampled at edge E0.
  - `set`/`rst` and `busy` go high in cycle E0+1.
  - The active drive stays high through cycle E0+PULSE_W and is low from cycle E0+PULSE_W+1.
- **Readback latency:** readback is sampled through the readback stage (see Configuration). Latency L=2 with the macro and L=0 without it.
- **Minimum `done`:** in cycle E0+PULSE_W+2, for a latch that flips during the pulse with L=0. With L=2 the same timing holds, because the synchronizer has filled during the pulse when PULSE_W≥2.
- **`err`:** in cycle E0+PULSE_W+TIMEOUT+1.
- **Back-to-back commands:** the next command can be accepted at the edge ending the `done`/`err` cycle.
- **`rst_n` low mid-PULSE or mid-WAIT:** at that edge, all outputs take their reset values. No `done`/`err` is produced, and the in-flight command is dropped.

## Configuration
- `SR_DRIVER_SYNC_EN` defined:
  - `q` and `q_` each pass through a 2-flop synchronizer (reset to 0) before comparison, so L=2.
  - WAIT compares only synchronized values.
- Not defined:
  - `q`/`q_` are compared directly at the WAIT edge, so L=0.
  - Use only when the latch is timed with `clk`.
- Handshake and pulse timing are identical in both builds.

## Test plan
Setup for all scenarios: PULSE_W=4, TIMEOUT=16, and a behavioural SR latch model with 1 ns delay on `q`/`q_`.
- **Reset release:** hold `rst_n`=0 for 3 cycles, then release. All outputs are 0 during reset, and `cmd_ready`=1 one cycle after release.
- **Set command:** `cmd_val`=1 with handshake at E0. `set`=1 in cycles E0+1 through E0+4, `rst`=0 throughout, and `done`=1 in cycle E0+6 with `q`=1.
- **Reset then set:** handshake `cmd_val`=0, then immediately handshake `cmd_val`=1 on the edge ending `done`. `rst` pulse, `done`, then `set` pulse, `done`. `set`&`rst` is never 1.
- **Stuck latch:** model `q`=0, `q_`=1 held, then command `cmd_val`=1. `err`=1 exactly in cycle E0+21, `done` never asserts, and `cmd_ready` returns in the same cycle as `err`.
- **Reset mid-PULSE:** drive `rst_n`=0 at E0+2 during a set command. `set`=0 from the next cycle, with no `done` and no `err`. A new command after release completes normally.
- **Ignored `cmd_valid`:** `cmd_valid` held high throughout a transaction. Exactly one pulse train per accepted handshake, and no extra command is accepted while `busy`=1.

Source files
------------

// File: rtl/sr_driver.sv
// Command-driven front end for a cross-coupled SR latch: pulses set/rst, then confirms q/q_.
// Define SR_DRIVER_SYNC_EN to pass q/q_ through 2-flop synchronizers before readback compare.
module sr_driver #(
    parameter int PULSE_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_val,
    output logic cmd_ready,
    output logic set,
    output logic rst,
    input  logic q,
    input  logic q_,
    output logic done,
    output logic err,
    output logic busy
);

    localparam int MAX_CNT = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_CNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          val, next_val;
    logic          next_done, next_err;
    logic          q_cmp, q_n_cmp;

`ifdef SR_DRIVER_SYNC_EN
    logic [1:0] q_sync, q_n_sync;

    // The latch is asynchronous to clk, so only the second flop feeds the compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_sync   <= 2'b00;
            q_n_sync <= 2'b00;
        end else begin
            q_sync   <= {q_sync[0], q};
            q_n_sync <= {q_n_sync[0], q_};
        end
    end

    assign q_cmp   = q_sync[1];
    assign q_n_cmp = q_n_sync[1];
`else
    assign q_cmp   = q;
    assign q_n_cmp = q_;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            val   <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            val   <= next_val;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_val   = val;
        next_done  = 1'b0;
        next_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    next_state = PULSE;
                    next_val   = cmd_val;
                    next_cnt   = '0;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    next_state = WAIT;
                    next_cnt   = '0;
                end else if (cnt != CNT_MAX) begin
                    next_cnt = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (q_cmp == val && q_n_cmp == !val) begin
                    next_state = IDLE;
                    next_done  = 1'b1;
                end else if (cnt == WAIT_LAST) begin
                    next_state = IDLE;
                    next_err   = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so set/rst come straight off flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            set       <= 1'b0;
            rst       <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_ready <= (next_state == IDLE);
            set       <= (next_state == PULSE) && next_val;
            rst       <= (next_state == PULSE) && !next_val;
            done      <= next_done;
            err       <= next_err;
            busy      <= (next_state != IDLE);
        end
    end

endmodule
